// File: rtl/multicycle_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_pkg : opcode/state encodings and opcode class helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_ADDI  = 3'd1,
    OP_XOR   = 3'd2,
    OP_LOAD  = 3'd3,
    OP_STORE = 3'd4,
    OP_JUMP  = 3'd5,
    OP_CMP   = 3'd6,
    OP_SHF   = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALTED = 3'd6,
    ST_ERROR  = 3'd7
  } state_e;

  function automatic logic is_mem(opcode_e op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic uses_imm(opcode_e op);
    return (op == OP_ADDI) || (op == OP_SHF);
  endfunction

  function automatic logic writes_reg(opcode_e op);
    return !((op == OP_STORE) || (op == OP_JUMP));
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_if : control, memory handshake and status bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             halt_req;
  logic [2:0]       opcode;
  logic             imem_req;
  logic             imem_ack;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ack;
  logic             ir_load;
  logic             pc_inc;
  logic             pc_load;
  logic             alu_src;
  logic             reg_write;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  start, halt_req, opcode, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load,
           alu_src, reg_write, busy, done, err, instr_cnt
  );

  modport slave (
    output start, halt_req, opcode, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load,
           alu_src, reg_write, busy, done, err, instr_cnt
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer : counts un-acked request cycles, flags the last allowed one
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expired
);
  localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [W-1:0] c_LIMIT = W'(MEM_TIMEOUT);

  logic [W-1:0] r_wait;

  // Never ticks past the limit: the owner leaves the wait state instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (i_clear) begin
      r_wait <= '0;
    end else if (i_tick) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  assign o_expired = (r_wait == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl : FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeouts
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);
  state_e           r_state;
  state_e           w_next;
  opcode_e          r_op;
  logic             r_halt;
  logic [CNT_W-1:0] r_cnt;

  logic w_imem_req, w_dmem_req, w_dmem_we, w_ir_load, w_pc_inc, w_pc_load;
  logic w_alu_src, w_reg_write, w_busy, w_done, w_err;
  logic w_retire, w_cnt_clr, w_wait_tick, w_expired;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (!w_wait_tick),
    .i_tick   (w_wait_tick),
    .o_expired(w_expired)
  );

  always_comb begin
    w_next      = r_state;
    w_imem_req  = 1'b0;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_ir_load   = 1'b0;
    w_pc_inc    = 1'b0;
    w_pc_load   = 1'b0;
    w_alu_src   = 1'b0;
    w_reg_write = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_retire    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_wait_tick = 1'b0;
    w_busy      = !(r_state inside {ST_IDLE, ST_HALTED, ST_ERROR});

    case (r_state)
      ST_IDLE, ST_HALTED: begin
        w_done = (r_state == ST_HALTED);
        if (bus.start) begin
          w_next    = ST_FETCH;
          w_cnt_clr = 1'b1;
        end
      end
      ST_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ack) begin
          w_ir_load = 1'b1;
          w_next    = ST_DECODE;
        end else if (w_expired) begin
          w_next = ST_ERROR;
        end else begin
          w_wait_tick = 1'b1;
        end
      end
      ST_DECODE: begin
        w_next = ST_EXEC;
      end
      ST_EXEC: begin
        w_alu_src = uses_imm(r_op);
        if (is_mem(r_op)) begin
          w_next = ST_MEM;
        end else if (writes_reg(r_op)) begin
          w_next = ST_WB;
        end else begin
          w_pc_load = 1'b1;
          w_retire  = 1'b1;
        end
      end
      ST_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (r_op == OP_STORE);
        if (bus.dmem_ack) begin
          if (writes_reg(r_op)) begin
            w_next = ST_WB;
          end else begin
            w_pc_inc = 1'b1;
            w_retire = 1'b1;
          end
        end else if (w_expired) begin
          w_next = ST_ERROR;
        end else begin
          w_wait_tick = 1'b1;
        end
      end
      ST_WB: begin
        w_reg_write = 1'b1;
        w_pc_inc    = 1'b1;
        w_retire    = 1'b1;
      end
      ST_ERROR: begin
        w_err = 1'b1;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase

    // A halt request seen in the retiring cycle itself still takes effect.
    if (w_retire) begin
      w_next = (r_halt || bus.halt_req) ? ST_HALTED : ST_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_ADD;
      r_halt  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_op <= opcode_e'(bus.opcode);
      end
      if (w_next == ST_HALTED) begin
        r_halt <= 1'b0;
      end else if (bus.halt_req && w_busy) begin
        r_halt <= 1'b1;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_retire && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.imem_req  = w_imem_req;
  assign bus.dmem_req  = w_dmem_req;
  assign bus.dmem_we   = w_dmem_we;
  assign bus.ir_load   = w_ir_load;
  assign bus.pc_inc    = w_pc_inc;
  assign bus.pc_load   = w_pc_load;
  assign bus.alu_src   = w_alu_src;
  assign bus.reg_write = w_reg_write;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.err       = w_err;
  assign bus.instr_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl : scoreboard bench with behavioural instruction/data memory
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int CW  = 2;
  localparam int TO  = 15;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CW)) bus();

  multicycle_ctrl #(
    .CNT_W      (CW),
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0] op;
    int         ilat;
    int         dlat;
  } prog_t;

  typedef struct {
    int cyc, ireq, irl, dreq, dwe, asrc, rw, pinc, pld, cnt;
  } exp_t;

  prog_t prog_q[$];
  exp_t  sb_q[$];
  int    checks = 0;
  int    failures = 0;
  int    model_cnt = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int outs_vec();
    return int'({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_load, bus.pc_inc,
                 bus.pc_load, bus.alu_src, bus.reg_write, bus.busy, bus.done, bus.err});
  endfunction

  // Expected per-instruction profile, derived from the opcode and the memory latencies.
  task automatic push_instr(input logic [2:0] op, input int ilat, input int dlat);
    prog_t p;
    exp_t  e;
    logic  mem, wr;
    mem = (op == OP_LOAD) || (op == OP_STORE);
    wr  = !((op == OP_STORE) || (op == OP_JUMP));
    e.cyc  = (ilat + 1) + 2 + (mem ? dlat + 1 : 0) + (wr ? 1 : 0);
    e.ireq = ilat + 1;
    e.irl  = 1;
    e.dreq = mem ? dlat + 1 : 0;
    e.dwe  = (op == OP_STORE) ? dlat + 1 : 0;
    e.asrc = ((op == OP_ADDI) || (op == OP_SHF)) ? 1 : 0;
    e.rw   = wr ? 1 : 0;
    e.pinc = (op == OP_JUMP) ? 0 : 1;
    e.pld  = (op == OP_JUMP) ? 1 : 0;
    if (model_cnt < MAXC) model_cnt++;
    e.cnt  = model_cnt;
    p.op = op; p.ilat = ilat; p.dlat = dlat;
    prog_q.push_back(p);
    sb_q.push_back(e);
  endtask

  // Memory responder and retire monitor.
  initial begin
    int   iw, dw, cur_dlat, op_hold, cnt_exp;
    logic cnt_pend;
    exp_t acc, e;
    iw = 0; dw = 0; cur_dlat = 0; op_hold = 0; cnt_exp = 0; cnt_pend = 1'b0;
    acc = '{default: 0};
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.opcode   = 3'd0;
    forever begin
      @(negedge clk);
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      if (op_hold > 0) op_hold--;
      else bus.opcode = 3'($urandom_range(0, 7));
      #1;
      if (!rst_n) begin
        prog_q.delete();
        sb_q.delete();
        iw = 0; dw = 0; cnt_pend = 1'b0;
        acc = '{default: 0};
      end else begin
        if (bus.imem_req) begin
          if (prog_q.size() > 0 && iw == prog_q[0].ilat) begin
            bus.imem_ack = 1'b1;
            bus.opcode   = prog_q[0].op;
            cur_dlat     = prog_q[0].dlat;
            op_hold      = 1;
            void'(prog_q.pop_front());
            iw = 0;
          end else iw++;
        end else iw = 0;
        if (bus.dmem_req) begin
          if (dw == cur_dlat) begin
            bus.dmem_ack = 1'b1;
            dw = 0;
          end else dw++;
        end else dw = 0;
        #1;
        if (cnt_pend) begin
          check_eq("instr_cnt", int'(bus.instr_cnt), cnt_exp);
          cnt_pend = 1'b0;
        end
        if (bus.busy) begin
          acc.cyc++;
          acc.ireq += int'(bus.imem_req);
          acc.irl  += int'(bus.ir_load);
          acc.dreq += int'(bus.dmem_req);
          acc.dwe  += int'(bus.dmem_req && bus.dmem_we);
          acc.asrc += int'(bus.alu_src);
          acc.rw   += int'(bus.reg_write);
          acc.pinc += int'(bus.pc_inc);
          acc.pld  += int'(bus.pc_load);
          if (bus.pc_inc || bus.pc_load) begin
            if (sb_q.size() == 0) begin
              check_eq("retire_expected", sb_q.size(), 1);
            end else begin
              e = sb_q.pop_front();
              check_eq("cycles",    acc.cyc,  e.cyc);
              check_eq("imem_req",  acc.ireq, e.ireq);
              check_eq("ir_load",   acc.irl,  e.irl);
              check_eq("dmem_req",  acc.dreq, e.dreq);
              check_eq("dmem_we",   acc.dwe,  e.dwe);
              check_eq("alu_src",   acc.asrc, e.asrc);
              check_eq("reg_write", acc.rw,   e.rw);
              check_eq("pc_inc",    acc.pinc, e.pinc);
              check_eq("pc_load",   acc.pld,  e.pld);
              cnt_pend = 1'b1;
              cnt_exp  = e.cnt;
            end
            acc = '{default: 0};
          end
        end else begin
          acc = '{default: 0};
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #3;
  endtask

  task automatic run_prog();
    int n;
    pulse_start();
    check_eq("cnt_cleared", int'(bus.instr_cnt), 0);
    n = 0;
    while (prog_q.size() > 0 && n < 2000) begin
      @(negedge clk); #3; n++;
    end
    check_eq("prog_drained", prog_q.size(), 0);
    @(negedge clk);
    bus.halt_req = 1'b1;
    @(negedge clk);
    bus.halt_req = 1'b0;
    #3;
    n = 0;
    while (!bus.done && n < 2000) begin
      @(negedge clk); #3; n++;
    end
    check_eq("done", int'(bus.done), 1);
    check_eq("busy_after_halt", int'(bus.busy), 0);
    check_eq("sb_drained", sb_q.size(), 0);
    check_eq("final_cnt", int'(bus.instr_cnt), model_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, reqs;
    bus.start    = 1'b0;
    bus.halt_req = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check_eq("rst_outs", outs_vec(), 0);
    check_eq("rst_cnt", int'(bus.instr_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ADD then halt.
    model_cnt = 0;
    push_instr(OP_ADD, 0, 0);
    run_prog();

    // LOAD with three data wait cycles.
    model_cnt = 0;
    push_instr(OP_LOAD, 0, 3);
    run_prog();

    // Mixed opcodes, including stores and jumps back to back.
    model_cnt = 0;
    push_instr(OP_STORE, 0, 0);
    push_instr(OP_JUMP,  0, 0);
    push_instr(OP_STORE, 1, 2);
    push_instr(OP_ADDI,  2, 0);
    push_instr(OP_SHF,   0, 0);
    push_instr(OP_XOR,   0, 0);
    push_instr(OP_CMP,   1, 0);
    push_instr(OP_JUMP,  3, 0);
    run_prog();

    // Counter saturation and acks on the very last permitted cycle.
    model_cnt = 0;
    for (int i = 0; i < 5; i++) push_instr(OP_ADD, i, 0);
    push_instr(OP_ADD,  TO, 0);
    push_instr(OP_LOAD, 0, TO);
    push_instr(OP_STORE, TO, TO);
    run_prog();
    check_eq("no_err_last_ack", int'(bus.err), 0);

    // Asynchronous reset while a data request is outstanding.
    model_cnt = 0;
    push_instr(OP_LOAD, 0, 10);
    pulse_start();
    n = 0;
    while (!bus.dmem_req && n < 50) begin
      @(negedge clk); #3; n++;
    end
    check_eq("dmem_req_seen", int'(bus.dmem_req), 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_outs", outs_vec(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #3;
    check_eq("post_rst_outs", outs_vec(), 0);
    check_eq("post_rst_cnt", int'(bus.instr_cnt), 0);

    // halt_req in IDLE must not be remembered.
    @(negedge clk);
    bus.halt_req = 1'b1;
    @(negedge clk);
    bus.halt_req = 1'b0;
    model_cnt = 0;
    push_instr(OP_ADD, 0, 0);
    push_instr(OP_XOR, 1, 0);
    run_prog();

    // Fetch never acknowledged.
    pulse_start();
    reqs = 0;
    n = 0;
    while (!bus.err && n < 40) begin
      if (bus.imem_req) reqs++;
      @(negedge clk); #3; n++;
    end
    check_eq("timeout_req_cycles", reqs, TO + 1);
    check_eq("err_set", int'(bus.err), 1);
    check_eq("err_req_dropped", int'(bus.imem_req), 0);
    pulse_start();
    repeat (3) @(negedge clk);
    #3;
    check_eq("err_sticky", int'(bus.err), 1);
    check_eq("err_not_busy", int'(bus.busy), 0);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #3;
    check_eq("final_rst_outs", outs_vec(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
